btn_step_gen: RTL and testbench
===============================

# btn_step_gen

Button conditioning stage directly upstream of the block-position logic. It synchronises and debounces the five push-buttons (up, down, left, right, centre) and turns direction presses into signed position steps. Steps are issued once per press, plus timed auto-repeat while held, over a valid/ready handshake. A separate one-cycle recentre strobe is produced for the centre button. The position register consumes the steps on the system clock, with no slow derived clock.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a debounced level changes.
- TICK_CYCLES, 1_666_667: clk cycles per repeat tick.
- REPEAT_DELAY_TICKS, 8: ticks a direction is held before auto-repeat starts.
- REPEAT_PERIOD_TICKS, 2: ticks between repeated steps.
- STEP, 4: step magnitude in pixels. Range 1..127.

Ports:
- clk, in, 1: system clock. The only clock.
- rst, in, 1: synchronous, active-high reset.
- up / down / left / right / centre, in, 1 each: raw asynchronous button levels.
- step_valid, out, 1: a step is pending.
- step_ready, in, 1: the consumer accepts the step.
- step_dx, out, 8: signed step in x. Positive means right.
- step_dy, out, 8: signed step in y. Positive means down.
- recentre, out, 1: one-cycle strobe on a debounced centre press.
- overrun, out, 1: sticky flag. Set when a step is dropped. Cleared only by rst.

## Operation
- **Synchroniser:** 2-FF per button.
- **Debounce:** one counter per button.
  - The counter resets whenever the synced value equals the debounced level.
  - When they differ for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes the synced value and the counter clears.
- **Tick prescaler:** counter 0..TICK_CYCLES-1, free-running. `tick` pulses on the wrap.
  - The prescaler counter clears when the FSM enters DELAY.
- **Direction vector:**
  - dx = STEP·(right − left).
  - dy = STEP·(down − up).
  - Values are taken from the debounced levels at emit time. Opposite directions pressed together cancel to 0.
- **FSM states:**
  - IDLE: wait for a rising edge on any debounced direction. On that edge, emit a step and go to DELAY.
  - DELAY: count ticks. At REPEAT_DELAY_TICKS, emit a step and go to REPEAT.
  - REPEAT: emit a step every REPEAT_PERIOD_TICKS ticks.
  - From DELAY or REPEAT: if every direction is released, go to IDLE.
  - From DELAY or REPEAT: a rising edge on another direction emits a step immediately and restarts DELAY.
- **Emit rules:**
  - A vector with dx = dy = 0 is not emitted.
  - If step_valid is already high and not accepted this cycle, the new step is dropped and overrun is set.
- **Handshake:**
  - step_valid, step_dx and step_dy are held stable until the cycle where step_valid && step_ready.
  - step_valid deasserts the cycle after acceptance unless a new emit occurs in the acceptance cycle. In that case the new step loads and valid stays high.
- **Recentre:** recentre pulses for 1 cycle on the cycle after the debounced centre rising edge. It is independent of the step handshake.
- **Reset values:**
  - All outputs 0. FSM in IDLE.
  - Debounced levels 0, synchronisers 0, all counters 0.
- **Reset mid-operation:** the pending step is discarded. A button held through reset release is treated as a new press once it has debounced.

## Timing
- Raw press at edge k → synced at k+2 → debounced at k+2+DEBOUNCE_CYCLES → step_valid high at k+3+DEBOUNCE_CYCLES.
- First repeat: REPEAT_DELAY_TICKS·TICK_CYCLES cycles after the initial emit, ±1 cycle.
- Repeat spacing: exactly REPEAT_PERIOD_TICKS·TICK_CYCLES cycles.
- Release: same debounce latency as a press. No emit after the debounced level falls.
- Width rules: step_dx and step_dy are two's complement 8-bit. Prescaler and debounce counters are sized by $clog2 of their parameter.

## Configuration
- BTN_AUTOREPEAT_EN defined: DELAY and REPEAT behave as described above.
- BTN_AUTOREPEAT_EN undefined:
  - Exactly one step per debounced rising edge.
  - The FSM returns to IDLE after each emit.
  - The tick prescaler is not built.

## Structure
- Shared package (game_pkg) holds:
  - the FSM state enum (IDLE, DELAY, REPEAT);
  - the step width constant (8);
  - the button index constants UP/DOWN/LEFT/RIGHT/CENTRE.
- One sub-module, btn_debounce: a single-bit synchroniser plus debounce counter, instantiated five times.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TICK_CYCLES=10, REPEAT_DELAY_TICKS=3, REPEAT_PERIOD_TICKS=2, STEP=4, with step_ready tied high unless stated.
- Glitch filter: right pulses high for 3 cycles → no step_valid.
- Single press: right held for 20 cycles then released.
  - step_valid pulses once, 7 cycles after the press, with dx=+4 and dy=0.
- Auto-repeat: up held for 150 cycles.
  - First step has dy=−4.
  - Second step follows 30 cycles later; subsequent steps every 20 cycles.
  - Without BTN_AUTOREPEAT_EN, exactly one step.
- Diagonal and cancel:
  - down+left pressed together → dx=−4, dy=+4.
  - left+right pressed together → no step.
- Backpressure: step_ready=0 while two presses occur.
  - The first step is held stable.
  - The second step is dropped and overrun=1.
  - Raising step_ready completes one transfer.
- Centre and reset:
  - Centre press → one recentre pulse 7 cycles after the press.
  - rst while step_valid=1 → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg : shared types and constants for the button/step front end
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package game_pkg;

  localparam int STEP_W  = 8;
  localparam int NUM_BTN = 5;

  localparam int UP     = 0;
  localparam int DOWN   = 1;
  localparam int LEFT   = 2;
  localparam int RIGHT  = 3;
  localparam int CENTRE = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } step_state_e;

  // Signed contribution of one axis: +mag, -mag, or 0 when both or neither pressed.
  function automatic logic [STEP_W-1:0] axis_step(input logic pos, input logic neg,
                                                  input logic [STEP_W-2:0] mag);
    logic [STEP_W-1:0] m;
    m = {1'b0, mag};
    if (pos && !neg) return m;
    else if (neg && !pos) return -m;
    else return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : 2-FF synchroniser plus stable-count debouncer for one button
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/btn_step_gen.sv
// ============================================================================
// btn_step_gen : debounced buttons -> signed position steps (valid/ready)
//                with one-cycle recentre strobe. Define BTN_AUTOREPEAT_EN to
//                build the hold-to-repeat state machine and tick prescaler.
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module btn_step_gen
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int TICK_CYCLES         = 1_666_667,
  parameter int REPEAT_DELAY_TICKS  = 8,
  parameter int REPEAT_PERIOD_TICKS = 2,
  parameter int STEP                = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic              centre,
  output logic              step_valid,
  input  logic              step_ready,
  output logic [STEP_W-1:0] step_dx,
  output logic [STEP_W-1:0] step_dy,
  output logic              recentre,
  output logic              overrun
);

  localparam logic [STEP_W-2:0] MAG = (STEP_W - 1)'(STEP);

  if (STEP < 1 || STEP > 127 || DEBOUNCE_CYCLES < 1 || TICK_CYCLES < 1 ||
      REPEAT_DELAY_TICKS < 1 || REPEAT_PERIOD_TICKS < 1) begin : g_bad_params
    $error("btn_step_gen: parameter out of range");
  end

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_lvl;
  logic [NUM_BTN-1:0] lvl_prev_q;
  logic [NUM_BTN-1:0] w_rise;
  logic               w_dir_rise;
  logic [STEP_W-1:0]  w_dx;
  logic [STEP_W-1:0]  w_dy;
  logic               w_trigger;
  logic               w_emit;
  logic               w_accept;

  // Bit order follows the UP..CENTRE index constants.
  assign w_raw = {centre, right, left, down, up};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (w_raw[gi]),
      .level_o(w_lvl[gi])
    );
  end

  assign w_rise     = w_lvl & ~lvl_prev_q;
  assign w_dir_rise = |w_rise[RIGHT:UP];
  assign w_dx       = axis_step(w_lvl[RIGHT], w_lvl[LEFT], MAG);
  assign w_dy       = axis_step(w_lvl[DOWN], w_lvl[UP], MAG);

`ifdef BTN_AUTOREPEAT_EN
  localparam int TMAX    = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                           REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
  localparam int TCNT_W  = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  step_state_e         state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [PRESC_W-1:0]  presc_q;
  logic                w_tick;
  logic                w_restart;
  logic                w_dir_held;
  logic                w_last_tick;

  assign w_tick     = (presc_q == PRESC_W'(TICK_CYCLES - 1));
  assign w_dir_held = |w_lvl[RIGHT:UP];
  assign w_last_tick = (state_q == DELAY) ? (tcnt_q == TCNT_W'(REPEAT_DELAY_TICKS - 1))
                                          : (tcnt_q == TCNT_W'(REPEAT_PERIOD_TICKS - 1));

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    w_trigger = 1'b0;
    w_restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_dir_rise) begin
          w_trigger = 1'b1;
          w_restart = 1'b1;
          state_d   = DELAY;
          tcnt_d    = '0;
        end
      end
      DELAY, REPEAT: begin
        if (!w_dir_held) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end else if (w_dir_rise) begin
          w_trigger = 1'b1;
          w_restart = 1'b1;
          state_d   = DELAY;
          tcnt_d    = '0;
        end else if (w_tick) begin
          if (w_last_tick) begin
            w_trigger = 1'b1;
            state_d   = REPEAT;
            tcnt_d    = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      // Re-aligning the prescaler makes the first repeat land on an exact tick count.
      if (w_restart || w_tick) presc_q <= '0;
      else                     presc_q <= presc_q + 1'b1;
    end
  end
`else
  assign w_trigger = w_dir_rise;
`endif

  assign w_emit   = w_trigger && ((w_dx != '0) || (w_dy != '0));
  assign w_accept = step_valid && step_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_valid <= 1'b0;
      step_dx    <= '0;
      step_dy    <= '0;
      recentre   <= 1'b0;
      overrun    <= 1'b0;
      lvl_prev_q <= '0;
    end else begin
      if (w_emit && (!step_valid || w_accept)) begin
        step_valid <= 1'b1;
        step_dx    <= w_dx;
        step_dy    <= w_dy;
      end else if (w_accept) begin
        step_valid <= 1'b0;
      end
      if (w_emit && step_valid && !w_accept) overrun <= 1'b1;
      recentre   <= w_rise[CENTRE];
      lvl_prev_q <= w_lvl;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_step_gen.sv
// ============================================================================
// tb_btn_step_gen : self-checking bench for btn_step_gen
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_btn_step_gen;
  import game_pkg::*;

  localparam int D   = 4;
  localparam int TK  = 10;
  localparam int RDT = 3;
  localparam int RPT = 2;
  localparam int ST  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, centre = 1'b0;
  logic       step_ready = 1'b1;
  logic       step_valid, recentre, overrun;
  logic [7:0] step_dx, step_dy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  btn_step_gen #(
    .DEBOUNCE_CYCLES    (D),
    .TICK_CYCLES        (TK),
    .REPEAT_DELAY_TICKS (RDT),
    .REPEAT_PERIOD_TICKS(RPT),
    .STEP               (ST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .centre    (centre),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .step_dx   (step_dx),
    .step_dy   (step_dy),
    .recentre  (recentre),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: buttons as sampled histories, steps as cycle arithmetic.
  logic [4:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_prev = '0;
  int         m_run [5] = '{0, 0, 0, 0, 0};
  bit         m_valid = 0, m_ovr = 0, m_rc = 0, m_active = 0;
  int         m_dx = 0, m_dy = 0, m_since = 0, m_target = 0;

  int acc_t[$], acc_dx[$], acc_dy[$], rc_t[$];

  always @(posedge clk) begin
    logic [4:0] raw, rise;
    bit emit, acc;
    int ex, ey;
    raw = {centre, right, left, down, up};
    cyc++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
      for (int b = 0; b < 5; b++) m_run[b] = 0;
      m_valid = 0; m_ovr = 0; m_rc = 0; m_active = 0;
      m_dx = 0; m_dy = 0; m_since = 0; m_target = 0;
    end else begin
      rise = m_lvl & ~m_prev;
      ex = ST * (int'(m_lvl[RIGHT]) - int'(m_lvl[LEFT]));
      ey = ST * (int'(m_lvl[DOWN]) - int'(m_lvl[UP]));
`ifdef BTN_AUTOREPEAT_EN
      emit = 0;
      if (!m_active) begin
        if (|rise[3:0]) begin
          emit = 1; m_active = 1; m_since = 0; m_target = RDT * TK;
        end
      end else if (m_lvl[3:0] == 4'b0) begin
        m_active = 0;
      end else if (|rise[3:0]) begin
        emit = 1; m_since = 0; m_target = RDT * TK;
      end else begin
        m_since++;
        if (m_since == m_target) begin
          emit = 1; m_target += RPT * TK;
        end
      end
`else
      emit = |rise[3:0];
`endif
      if (ex == 0 && ey == 0) emit = 0;
      acc = m_valid && step_ready;
      if (emit) begin
        if (m_valid && !acc) m_ovr = 1;
        else begin m_valid = 1; m_dx = ex; m_dy = ey; end
      end else if (acc) begin
        m_valid = 0;
      end
      m_rc   = rise[CENTRE];
      m_prev = m_lvl;
      for (int b = 0; b < 5; b++) begin
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin m_lvl[b] = m_s2[b]; m_run[b] = 0; end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  always @(negedge clk) begin
    bit bad;
    if (cyc > 0) begin
      bad = (step_valid !== m_valid) || (overrun !== m_ovr) || (recentre !== m_rc) ||
            (m_valid && ((step_dx !== 8'(m_dx)) || (step_dy !== 8'(m_dy))));
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL model cyc=%0d: got v=%b dx=%0d dy=%0d ovr=%b rc=%b, want v=%b dx=%0d dy=%0d ovr=%b rc=%b",
                 cyc, step_valid, $signed(step_dx), $signed(step_dy), overrun, recentre,
                 m_valid, m_dx, m_dy, m_ovr, m_rc);
      end
      if (step_valid === 1'b1 && step_ready === 1'b1) begin
        acc_t.push_back(cyc);
        acc_dx.push_back(int'($signed(step_dx)));
        acc_dy.push_back(int'($signed(step_dy)));
      end
      if (recentre === 1'b1) rc_t.push_back(cyc);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -9999;
  endfunction

  task automatic clear_logs();
    acc_t.delete(); acc_dx.delete(); acc_dy.delete(); rc_t.delete();
  endtask

  initial begin
    int p, r;
    wait_cyc(3);
    chk("reset_valid", int'(step_valid), 0);
    chk("reset_dx", int'(step_dx), 0);
    chk("reset_dy", int'(step_dy), 0);
    chk("reset_recentre", int'(recentre), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    wait_cyc(5);

    // Three-cycle glitch must not survive a four-cycle debounce.
    clear_logs();
    right = 1'b1; wait_cyc(3); right = 1'b0; wait_cyc(20);
    chk("glitch_steps", acc_t.size(), 0);

    clear_logs();
    p = cyc; right = 1'b1; wait_cyc(20); right = 1'b0; wait_cyc(20);
    chk("single_count", acc_t.size(), 1);
    chk("single_latency", qget(acc_t, 0) - p, 7);
    chk("single_dx", qget(acc_dx, 0), 4);
    chk("single_dy", qget(acc_dy, 0), 0);

    clear_logs();
    p = cyc; up = 1'b1; wait_cyc(150); up = 1'b0; wait_cyc(30);
    chk("hold_latency", qget(acc_t, 0) - p, 7);
    chk("hold_dy", qget(acc_dy, 0), -4);
    chk("hold_dx", qget(acc_dx, 0), 0);
`ifdef BTN_AUTOREPEAT_EN
    chk("hold_count", acc_t.size(), 7);
    chk("hold_first_gap", qget(acc_t, 1) - qget(acc_t, 0), 30);
    chk("hold_second_gap", qget(acc_t, 2) - qget(acc_t, 1), 20);
    chk("hold_last_gap", qget(acc_t, 6) - qget(acc_t, 5), 20);
`else
    chk("hold_count", acc_t.size(), 1);
`endif

    clear_logs();
    down = 1'b1; left = 1'b1; wait_cyc(12); down = 1'b0; left = 1'b0; wait_cyc(20);
    chk("diag_count", acc_t.size(), 1);
    chk("diag_dx", qget(acc_dx, 0), -4);
    chk("diag_dy", qget(acc_dy, 0), 4);

    clear_logs();
    left = 1'b1; right = 1'b1; wait_cyc(12); left = 1'b0; right = 1'b0; wait_cyc(20);
    chk("cancel_count", acc_t.size(), 0);

    clear_logs();
    p = cyc; centre = 1'b1; wait_cyc(12); centre = 1'b0; wait_cyc(20);
    chk("centre_pulses", rc_t.size(), 1);
    chk("centre_latency", qget(rc_t, 0) - p, 7);
    chk("centre_steps", acc_t.size(), 0);

    // Backpressure: second press arrives while the first step is still held.
    clear_logs();
    step_ready = 1'b0;
    right = 1'b1; wait_cyc(10); right = 1'b0; wait_cyc(12);
    down = 1'b1; wait_cyc(10); down = 1'b0; wait_cyc(12);
    chk("bp_valid_held", int'(step_valid), 1);
    chk("bp_dx_held", int'($signed(step_dx)), 4);
    chk("bp_dy_held", int'($signed(step_dy)), 0);
    chk("bp_overrun", int'(overrun), 1);
    chk("bp_no_transfer", acc_t.size(), 0);
    step_ready = 1'b1; wait_cyc(1); step_ready = 1'b0; wait_cyc(3);
    chk("bp_one_transfer", acc_t.size(), 1);
    chk("bp_valid_after", int'(step_valid), 0);
    chk("bp_overrun_sticky", int'(overrun), 1);

    // Reset with a pending step, button held through reset release.
    right = 1'b1; wait_cyc(10);
    chk("rstmid_pending", int'(step_valid), 1);
    rst = 1'b1; wait_cyc(1);
    chk("rstmid_valid", int'(step_valid), 0);
    chk("rstmid_overrun", int'(overrun), 0);
    chk("rstmid_dx", int'(step_dx), 0);
    chk("rstmid_recentre", int'(recentre), 0);
    wait_cyc(2);
    rst = 1'b0; r = cyc;
    wait_cyc(6);
    chk("rstmid_not_yet", int'(step_valid), 0);
    wait_cyc(1);
    chk("rstmid_repress", int'(step_valid), 1);
    chk("rstmid_repress_dx", int'($signed(step_dx)), 4);
    chk("rstmid_cycle", cyc - r, 7);
    step_ready = 1'b1; right = 1'b0; wait_cyc(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
